// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction alignment mask, default datapath width.
package cpu_pkg;

    localparam int N = 32;

    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HOLD,
        ERR
    } fetch_state_t;

endpackage

// File: rtl/single_ifetch.sv
// Single-outstanding instruction fetch stage: samples pc, requests one word from imem,
// holds it for decode, and pulses pc_en when decode takes it without a redirect.
module single_ifetch #(
    parameter int N       = cpu_pkg::N,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pc,
    input  logic         flush,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] instr,
    output logic [N-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic         pc_en,
    output logic         fetch_err
);
    import cpu_pkg::*;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    fetch_state_t  state, state_nx;
    logic [N-1:0]  req_pc, req_pc_nx;
    logic [N-1:0]  imem_addr_nx, instr_nx, instr_pc_nx;
    logic          imem_req_nx, instr_valid_nx, fetch_err_nx;
    logic          drop, drop_nx;
    logic [CW-1:0] wait_cnt, wait_cnt_nx;
    logic          misaligned;

    assign misaligned = (pc[1:0] & INSTR_ALIGN_MASK) != 2'b00;

    // Only the hand-off pulse is combinational so a same-cycle flush can veto the PC advance.
    assign pc_en = instr_valid & instr_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ISSUE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            req_pc      <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            drop        <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_nx;
            imem_req    <= imem_req_nx;
            imem_addr   <= imem_addr_nx;
            req_pc      <= req_pc_nx;
            instr       <= instr_nx;
            instr_pc    <= instr_pc_nx;
            instr_valid <= instr_valid_nx;
            fetch_err   <= fetch_err_nx;
            drop        <= drop_nx;
            wait_cnt    <= wait_cnt_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        imem_req_nx    = 1'b0;
        imem_addr_nx   = imem_addr;
        req_pc_nx      = req_pc;
        instr_nx       = instr;
        instr_pc_nx    = instr_pc;
        instr_valid_nx = instr_valid;
        fetch_err_nx   = fetch_err;
        drop_nx        = drop;
        wait_cnt_nx    = wait_cnt;

        case (state)
            ISSUE: begin
                if (!flush) begin
                    if (misaligned) begin
                        fetch_err_nx = 1'b1;
                        state_nx     = ERR;
                    end else begin
                        imem_req_nx  = 1'b1;
                        imem_addr_nx = pc;
                        req_pc_nx    = pc;
                        wait_cnt_nx  = '0;
                        drop_nx      = 1'b0;
                        state_nx     = WAIT;
                    end
                end
            end
            WAIT: begin
                // A redirect seen while waiting poisons the in-flight response, whenever it lands.
                if (imem_rvalid) begin
                    if (drop || flush) begin
                        drop_nx  = 1'b0;
                        state_nx = ISSUE;
                    end else begin
                        instr_nx       = imem_rdata;
                        instr_pc_nx    = req_pc;
                        instr_valid_nx = 1'b1;
                        state_nx       = HOLD;
                    end
                end else begin
                    if (flush) begin
                        drop_nx = 1'b1;
                    end
                    wait_cnt_nx = wait_cnt + CW'(1);
                    if (wait_cnt == CNT_LAST) begin
                        fetch_err_nx = 1'b1;
                        state_nx     = ERR;
                    end
                end
            end
            HOLD: begin
                if (flush || instr_ready) begin
                    instr_valid_nx = 1'b0;
                    state_nx       = ISSUE;
                end
            end
            ERR: begin
                instr_valid_nx = 1'b0;
            end
            default: begin
                state_nx = ISSUE;
            end
        endcase
    end

endmodule

// File: doc/single_ifetch.md
Name: single_ifetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Samples the current PC, issues one request per instruction to the instruction memory (variable-latency valid handshake), and holds the returned word for decode behind a valid/ready handshake.
- Pulses pc_en so the upstream next-PC logic advances the PC only when decode accepts an instruction.
- Handles branch/jump flush, misaligned PCs and memory timeout.

Parameters:
- N, 32, address and instruction width.
- TIMEOUT, 16, maximum number of WAIT cycles before a missing response is flagged as an error (must be at least 1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc  in  N  current PC, from the PC register output.
- flush  in  1  one-cycle redirect; upstream loads the new target into the PC on the same edge.
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  N  request address, valid while imem_req=1.
- imem_rvalid  in  1  response valid; at most one response per request.
- imem_rdata  in  N  response word, valid with imem_rvalid.
- instr  out  N  fetched instruction to decode.
- instr_pc  out  N  PC of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts instr.
- pc_en  out  1  advance-PC pulse, combinational: instr_valid & instr_ready & ~flush.
- fetch_err  out  1  sticky error (misaligned PC or timeout).

Behaviour:
- Reset values: imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, fetch_err=0, pc_en=0, drop=0, wait_cnt=0, state=ISSUE.
- rst has priority over all inputs. A reset asserted in any state (including mid-WAIT) returns the block to ISSUE. A response arriving after reset while in ISSUE is ignored.
- All outputs except pc_en are registered.
- FSM states: ISSUE, WAIT, HOLD, ERR.
- ISSUE:
  - If flush: stay in ISSUE and re-sample pc next cycle.
  - Else if pc[1:0]!=0: fetch_err<=1, go to ERR, no request issued.
  - Else: imem_req<=1, imem_addr<=pc, req_pc<=pc, wait_cnt<=0, go to WAIT.
- WAIT:
  - imem_req<=0.
  - flush without rvalid: drop<=1, stay in WAIT.
  - rvalid with (drop or flush): discard imem_rdata, drop<=0, go to ISSUE.
  - rvalid with neither: instr<=imem_rdata, instr_pc<=req_pc, instr_valid<=1, go to HOLD.
  - No rvalid: wait_cnt increments. If wait_cnt==TIMEOUT-1: fetch_err<=1, go to ERR.
- HOLD:
  - instr and instr_pc are held stable while instr_valid=1 and not accepted.
  - flush: instr_valid<=0, go to ISSUE; pc_en=0 even if ready.
  - instr_ready: instr_valid<=0, go to ISSUE; pc_en=1 this cycle.
- ERR: terminal until rst. All inputs ignored, instr_valid=0, imem_req=0.
- Latency:
  - Request pulse appears 1 cycle after entering ISSUE.
  - instr_valid rises on the edge that samples imem_rvalid.
  - Minimum accept-to-next-accept spacing is 3 cycles plus memory latency.
- Exactly one outstanding request at any time. imem_req is never high for two consecutive cycles.
- wait_cnt width: $clog2(TIMEOUT+1) bits, no wrap; cleared on every WAIT entry.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state enum (ISSUE, WAIT, HOLD, ERR);
  - the INSTR_ALIGN_MASK constant (2'b11);
  - the default width constant N=32.
- No sub-module needed; FSM and timeout counter live in one module.

Test Plan:
- Reset then pc=0x00000000, memory responds 2 cycles after the request with 0x20080005, decode ready=1 -> imem_req pulse with addr 0x0; instr=0x20080005, instr_pc=0x0, instr_valid 1 cycle; pc_en=1 on the accept cycle.
- Decode ready=0 for 5 cycles after instr_valid -> instr and instr_pc stable, pc_en=0, no new imem_req; accept on the 6th cycle -> next request uses the updated pc=0x4.
- flush in WAIT (pc redirected to 0x40), late response 0xDEADBEEF -> response discarded, instr_valid stays 0, next request addr 0x40.
- flush coincident with imem_rvalid, and separately flush coincident with accept in HOLD -> both discard the instruction; pc_en=0; next request uses the redirected pc.
- pc=0x00000006 in ISSUE -> no imem_req, fetch_err=1 next cycle and sticky; rst clears it and the bench restarts with pc=0x0.
- No response for TIMEOUT=16 WAIT cycles -> fetch_err=1 after the 16th; a later rvalid is ignored; rst mid-WAIT on another run returns to ISSUE with all outputs at reset values.
